packet_register: RTL and testbench



---
 rtl/packet_register.sv | 135 +++++++++++++
 tb/tb_packet_register.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/packet_register.sv
// Router datapath register stage: byte staging to the destination FIFOs, running parity and FSM handshake flags.
// Optional payload byte counter and o_Sig_Length_Error enabled by defining PKT_REG_BYTE_COUNT_EN.
module packet_register #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_Sig_Packet_Valid,
   input  logic [DATA_WIDTH-1:0] i_Input_Data,
   input  logic                  i_Sig_Fifo_Full,
   input  logic                  i_Sig_Address_Detected,
   input  logic                  i_Load_First_Data_State,
   input  logic                  i_Load_Data_State,
   input  logic                  i_Full_State,
   input  logic                  i_Load_After_State,
   input  logic                  i_Reset_Low_Packet_Valid_Reg,
   output logic [DATA_WIDTH-1:0] o_Data_Out,
   output logic                  o_Sig_Parity_Done,
   output logic                  o_Sig_Low_Packet_Valid,
   output logic                  o_Sig_Error
`ifdef PKT_REG_BYTE_COUNT_EN
   ,
   output logic                  o_Sig_Length_Error
`endif
);

   logic [DATA_WIDTH-1:0] r_header, r_hold, r_data_out, r_parity, r_parity_cap;
   logic                  r_hold_payload, r_parity_done, r_done_d, r_low_pv, r_error;
   logic                  w_first, w_data, w_after, w_hdr_cap, w_fold_data, w_fold_after;
   logic                  w_done_set, w_done_rise, w_err_clr, w_unused;

   // FIFO_FULL by itself only holds state, so every register simply keeps its value.
   assign w_unused     = i_Full_State;

   assign w_first      = i_Load_First_Data_State;
   assign w_data       = !w_first & i_Load_Data_State;
   assign w_after      = !w_first & !i_Load_Data_State & i_Load_After_State;
   assign w_hdr_cap    = i_Sig_Address_Detected & i_Sig_Packet_Valid & (i_Input_Data[1:0] != 2'b11);
   assign w_fold_data  = w_data & i_Sig_Packet_Valid & !i_Sig_Fifo_Full;
   // The held byte might be the parity byte, which must stay out of the running parity.
   assign w_fold_after = w_after & r_hold_payload;
   assign w_done_set   = (w_data & !i_Sig_Fifo_Full & !i_Sig_Packet_Valid) |
                         (w_after & r_low_pv & !r_parity_done);
   assign w_done_rise  = r_parity_done & !r_done_d;
   assign w_err_clr    = i_Sig_Address_Detected & i_Sig_Packet_Valid;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_header       <= '0;
         r_hold         <= '0;
         r_hold_payload <= 1'b0;
         r_data_out     <= '0;
         r_parity       <= '0;
         r_parity_cap   <= '0;
         r_parity_done  <= 1'b0;
         r_done_d       <= 1'b0;
         r_low_pv       <= 1'b0;
         r_error        <= 1'b0;
      end else begin
         if (w_hdr_cap)
            r_header <= i_Input_Data;

         if (w_first)
            r_data_out <= r_header;
         else if (w_data & !i_Sig_Fifo_Full)
            r_data_out <= i_Input_Data;
         else if (w_after)
            r_data_out <= r_hold;

         if (w_data & i_Sig_Fifo_Full) begin
            r_hold         <= i_Input_Data;
            r_hold_payload <= i_Sig_Packet_Valid;
         end

         if (i_Sig_Address_Detected)
            r_parity <= '0;
         else if (w_first)
            r_parity <= r_parity ^ r_header;
         else if (w_fold_data)
            r_parity <= r_parity ^ i_Input_Data;
         else if (w_fold_after)
            r_parity <= r_parity ^ r_hold;

         if (w_data & !i_Sig_Packet_Valid)
            r_parity_cap <= i_Input_Data;

         if (w_done_set)
            r_parity_done <= 1'b1;
         else if (i_Sig_Address_Detected)
            r_parity_done <= 1'b0;
         r_done_d <= r_parity_done;

         if (w_data & !i_Sig_Packet_Valid)
            r_low_pv <= 1'b1;
         else if (i_Reset_Low_Packet_Valid_Reg)
            r_low_pv <= 1'b0;

         if (w_done_rise)
            r_error <= (r_parity != r_parity_cap);
         else if (w_err_clr)
            r_error <= 1'b0;
      end
   end

`ifdef PKT_REG_BYTE_COUNT_EN
   localparam int CW = DATA_WIDTH - 2;
   logic [CW-1:0] r_count;
   logic          r_len_err;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count   <= '0;
         r_len_err <= 1'b0;
      end else begin
         if (w_hdr_cap)
            r_count <= '0;
         else if ((w_fold_data | w_fold_after) && (r_count != '1))
            r_count <= r_count + CW'(1);

         if (w_done_rise)
            r_len_err <= (r_count != r_header[DATA_WIDTH-1:2]);
         else if (w_err_clr)
            r_len_err <= 1'b0;
      end
   end

   assign o_Sig_Length_Error = r_len_err;
`endif

   assign o_Data_Out             = r_data_out;
   assign o_Sig_Parity_Done      = r_parity_done;
   assign o_Sig_Low_Packet_Valid = r_low_pv;
   assign o_Sig_Error            = r_error;

endmodule

// File: tb/tb_packet_register.sv
// Scoreboard bench for packet_register: the driver plays the router FSM, the monitor checks FIFO writes and parity verdicts.
module tb_packet_register;
   localparam int DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b0;
   logic          pv = 1'b0, full = 1'b0, adet = 1'b0, lfirst = 1'b0, ldata = 1'b0;
   logic          lfull = 1'b0, lafter = 1'b0, rlow = 1'b0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout;
   logic          pdone, lowpv, err;
`ifdef PKT_REG_BYTE_COUNT_EN
   logic          lenerr;
`endif

   packet_register #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .i_Sig_Packet_Valid(pv), .i_Input_Data(din), .i_Sig_Fifo_Full(full),
      .i_Sig_Address_Detected(adet), .i_Load_First_Data_State(lfirst),
      .i_Load_Data_State(ldata), .i_Full_State(lfull), .i_Load_After_State(lafter),
      .i_Reset_Low_Packet_Valid_Reg(rlow),
      .o_Data_Out(dout), .o_Sig_Parity_Done(pdone),
      .o_Sig_Low_Packet_Valid(lowpv), .o_Sig_Error(err)
`ifdef PKT_REG_BYTE_COUNT_EN
      , .o_Sig_Length_Error(lenerr)
`endif
   );

   int checks = 0, errors = 0;
   logic [DW-1:0] exp_bytes[$];   // bytes the destination FIFO must receive, in order
   logic [1:0]    exp_flags[$];   // per packet {parity error, length error}
   logic [DW-1:0] pay[64];
   bit            fm[65];
   bit            last_err = 1'b0;
   logic [DW-1:0] last_hdr = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic       tb_we = 1'b0, tb_we_q = 1'b0, prev_done = 1'b0, pend = 1'b0;
   logic [1:0] f;
   always @(posedge clk) tb_we_q <= tb_we;

   always @(negedge clk) begin
      if (tb_we_q) begin
         if (exp_bytes.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write got %0h expected none", dout);
         end else chk("data_out", dout, exp_bytes.pop_front());
      end
      if (pend) begin
         if (exp_flags.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_parity_done got 1 expected 0");
         end else begin
            f = exp_flags.pop_front();
            chk("sig_error", err, f[1]);
`ifdef PKT_REG_BYTE_COUNT_EN
            chk("length_error", lenerr, f[0]);
`endif
         end
      end
      pend      <= pdone & !prev_done;
      prev_done <= pdone;
   end

   // ---------------- driver ----------------
   task automatic step(input bit a, input bit fi, input bit d, input bit af, input bit fs,
                       input bit rl, input bit p, input bit fu, input logic [DW-1:0] data,
                       input bit we);
      adet = a; lfirst = fi; ldata = d; lafter = af; lfull = fs; rlow = rl;
      pv = p; full = fu; din = data; tb_we = we;
      @(posedge clk); #1;
      tb_we = 1'b0;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, DW'($urandom), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_data_out"}, dout, 0);
      chk({tag, "_parity_done"}, pdone, 0);
      chk({tag, "_low_pv"}, lowpv, 0);
      chk({tag, "_error"}, err, 0);
`ifdef PKT_REG_BYTE_COUNT_EN
      chk({tag, "_length_error"}, lenerr, 0);
`endif
   endtask

   task automatic apply_reset(input int n, input string tag);
      reset = 1'b0; tb_we = 1'b0;
      repeat (n) begin
         {adet, lfirst, ldata, lafter, lfull, rlow, pv, full} = 8'($urandom);
         din = DW'($urandom);
         @(posedge clk); #1;
      end
      check_reset_outputs(tag);
      reset = 1'b1;
      {adet, lfirst, ldata, lafter, lfull, rlow, pv, full} = '0;
      last_err = 1'b0;
   endtask

   // Packet: header {len, addr}, nsent payload bytes from pay[], parity byte xor-corrupted by cmask.
   // fm[i] stalls byte i (fm[nsent] = parity byte) for 'stall' FIFO_FULL cycles.
   task automatic send_packet(input int addr, input int len, input int nsent,
                              input logic [DW-1:0] cmask, input int stall);
      logic [DW-1:0] hdr, par;
      hdr = {6'(len), 2'(addr)};
      par = hdr;
      for (int i = 0; i < nsent; i++) par = par ^ pay[i];
      exp_flags.push_back({cmask != 0, nsent != len});
      par = par ^ cmask;

      chk("error_hold", err, last_err);
      step(1, 0, 0, 0, 0, 0, 1, 0, hdr, 0);
      chk("error_clear", err, 0);
      chk("done_clear", pdone, 0);
      exp_bytes.push_back(hdr);
      step(0, 1, 0, 0, 0, 0, 1, 0, DW'($urandom), 1);
      for (int i = 0; i < nsent; i++) begin
         exp_bytes.push_back(pay[i]);
         step(0, 0, 1, 0, 0, 0, 1, fm[i], pay[i], !fm[i]);
         if (fm[i]) begin
            repeat (stall) step(0, 0, 0, 0, 1, 0, 1, 1, DW'($urandom), 0);
            step(0, 0, 0, 1, 0, 0, 1, 0, DW'($urandom), 1);
         end
      end
      exp_bytes.push_back(par);
      step(0, 0, 1, 0, 0, 0, 0, fm[nsent], par, !fm[nsent]);
      chk("low_pv_set", lowpv, 1);
      if (!fm[nsent]) begin
         chk("done_direct", pdone, 1);
         idle();
      end else begin
         chk("done_wait_full", pdone, 0);
         repeat (stall) step(0, 0, 0, 0, 1, 0, 0, 1, DW'($urandom), 0);
         step(0, 0, 0, 1, 0, 0, 0, 0, DW'($urandom), 1);
         chk("done_after_full", pdone, 1);
      end
      step(0, 0, 0, 0, 0, 1, 0, 0, DW'($urandom), 0);
      chk("low_pv_clear", lowpv, 0);
      idle();
      last_err = (cmask != 0);
      last_hdr = hdr;
   endtask

   task automatic clear_fm();
      for (int i = 0; i < 65; i++) fm[i] = 1'b0;
   endtask

   initial begin
      apply_reset(2, "reset");
      idle();

      clear_fm();
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
      send_packet(0, 3, 3, 8'h00, 0);                   // clean: 0C,11,22,33,0C
      send_packet(0, 3, 3, 8'h0C ^ 8'hFF, 0);           // parity byte FF
      fm[1] = 1'b1;
      send_packet(0, 3, 3, 8'h00, 3);                   // full while 22 on bus
      clear_fm(); fm[3] = 1'b1;
      send_packet(1, 3, 3, 8'h00, 2);                   // parity byte under full
      clear_fm();
      send_packet(2, 3, 2, 8'h00, 0);                   // two payload bytes for length 3

      // Header with address 3 is ignored: LOAD_FIRST still presents the previous header.
      step(1, 0, 0, 0, 0, 0, 1, 0, {6'($urandom), 2'b11}, 0);
      last_err = 1'b0;
      exp_bytes.push_back(last_hdr);
      step(0, 1, 0, 0, 0, 0, 1, 0, DW'($urandom), 1);
      idle();

      // Reset mid-packet with a payload byte parked in the hold register.
      step(1, 0, 0, 0, 0, 0, 1, 0, 8'h15, 0);
      exp_bytes.push_back(8'h15);
      step(0, 1, 0, 0, 0, 0, 1, 0, DW'($urandom), 1);
      step(0, 0, 1, 0, 0, 0, 1, 1, 8'hA5, 0);
      step(0, 0, 0, 0, 1, 0, 1, 1, DW'($urandom), 0);
      apply_reset(1, "mid_reset");
      exp_bytes.push_back(8'h00);
      step(0, 0, 0, 1, 0, 0, 1, 0, DW'($urandom), 1);
      chk("mid_reset_no_done", pdone, 0);
      idle();

      for (int k = 0; k < 25; k++) begin
         int len, st;
         len = $urandom_range(1, 6);
         st  = $urandom_range(1, 3);
         for (int i = 0; i <= len; i++) begin
            pay[i] = DW'($urandom);
            fm[i]  = ($urandom_range(0, 3) == 0);
         end
         send_packet($urandom_range(0, 2), len, len,
                     ($urandom_range(0, 1) == 1) ? DW'($urandom_range(1, 255)) : 8'h00, st);
      end

      repeat (3) idle();
      chk("bytes_drained", exp_bytes.size(), 0);
      chk("flags_drained", exp_flags.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
